fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 92 +++++++++
 tb/tb_fir_decimator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - block-average decimator with output FIFO and sticky overflow
module fir_decimator #(
  parameter int DATA_W     = 8,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic signed [DATA_W-1:0]            in_sig,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [DATA_W-1:0]            out_sig,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow,
  input  logic                                clr_ovf
);

  localparam int DECIM = 1 << DECIM_LOG2;
  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PH_W-1:0]         phase;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic [DATA_W-1:0]       result;
  logic                    last;

  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LVL_W-1:0]        level;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    accept;
  logic                    drop;

  // Accumulator is DECIM_LOG2 bits wider than a sample, so a full block cannot overflow it.
  assign in_ext = ACC_W'(in_sig);
  assign sum    = ((phase == '0) ? '0 : acc) + in_ext;
  assign result = DATA_W'(sum >>> DECIM_LOG2);
  assign last   = (phase == PH_W'(DECIM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      acc   <= '0;
    end else if (in_valid) begin
      phase <= last ? '0 : phase + PH_W'(1);
      acc   <= last ? '0 : sum;
    end
  end

  assign push   = in_valid && last;
  assign pop    = out_valid && out_ready;
  assign full   = (level == LVL_W'(FIFO_DEPTH));
  // A pop on the same edge frees the head slot, so a full FIFO can still take the push.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign out_valid  = (level != '0);
  assign out_sig    = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - directed vector bench for fir_decimator
module tb_fir_decimator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] in_sig;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_sig;
  logic [3:0]        fifo_level;
  logic              overflow;
  logic              clr_ovf;

  logic              o0_valid;
  logic signed [7:0] o0_sig;
  logic [3:0]        o0_level;
  logic              o0_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int s3;
    int exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  fir_decimator #(.DATA_W(8), .DECIM_LOG2(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig),
    .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  fir_decimator #(.DATA_W(8), .DECIM_LOG2(0), .FIFO_DEPTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sig(in_sig),
    .out_valid(o0_valid), .out_ready(1'b1), .out_sig(o0_sig),
    .fifo_level(o0_level), .overflow(o0_ovf), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_sig   = 8'(v);
    tick();
    in_valid = 1'b0;
    chk("dec1_valid", int'(o0_valid), 1);
    chk("dec1_sig", int'(o0_sig), v);
  endtask

  task automatic feed4(input int v);
    for (int i = 0; i < 4; i++) feed(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{20, 20, 20, 20, 20};
    vecs[1] = '{-1, -2, -3, -4, -3};
    vecs[2] = '{127, 127, 127, 127, 127};
    vecs[3] = '{-128, -128, -128, -128, -128};
    vecs[4] = '{1, 2, 3, 4, 2};
    vecs[5] = '{-1, 0, 0, 0, -1};
    vecs[6] = '{5, 5, 5, 6, 5};
    vecs[7] = '{100, -100, 3, -4, -1};

    rst_n = 1'b0; in_valid = 1'b0; in_sig = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_sig", int'(out_sig), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      feed(vecs[v].s0);
      feed(vecs[v].s1);
      feed(vecs[v].s2);
      chk("vec_early_valid", int'(out_valid), 0);
      feed(vecs[v].s3);
      chk("vec_valid", int'(out_valid), 1);
      chk("vec_sig", int'(out_sig), vecs[v].exp);
      tick();
      chk("vec_popped", int'(out_valid), 0);
    end

    // Continuous stream: one-cycle pulses after input edges 4 and 8.
    for (int k = 1; k <= 8; k++) begin
      feed(20);
      chk("stream_valid", int'(out_valid), (k == 4 || k == 8) ? 1 : 0);
      if (k == 4 || k == 8) chk("stream_sig", int'(out_sig), 20);
    end
    tick();

    // Gapped input: invalid cycles carry junk that must be ignored.
    for (int k = 0; k < 4; k++) begin
      feed(4 * (k + 1));
      if (k < 3) chk("gap_valid", int'(out_valid), 0);
      else begin
        chk("gap_valid_last", int'(out_valid), 1);
        chk("gap_sig", int'(out_sig), 10);
      end
      in_sig = 8'sd99;
      tick();
      if (k < 3) chk("gap_idle_valid", int'(out_valid), 0);
    end

    // Backpressure: 10 results into an 8-deep FIFO.
    out_ready = 1'b0;
    for (int r = 0; r < 10; r++) begin
      feed(3 * r + 1); feed(3 * r + 1); feed(3 * r + 1);
      if (r == 9) clr_ovf = 1'b1;
      feed(3 * r + 1);
      clr_ovf = 1'b0;
      if (r == 7) begin
        chk("bp_level8", int'(fifo_level), 8);
        chk("bp_ovf_before", int'(overflow), 0);
      end
      if (r == 8) begin
        chk("bp_level_full", int'(fifo_level), 8);
        chk("bp_ovf_set", int'(overflow), 1);
      end
      if (r == 9) chk("bp_drop_beats_clr", int'(overflow), 1);
    end
    tick();
    chk("bp_hold_sig", int'(out_sig), 1);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_sig", int'(out_sig), 3 * r + 1);
      tick();
    end
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_valid_end", int'(out_valid), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", int'(overflow), 0);

    // Full FIFO with simultaneous pop and push.
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) feed4(10 + r);
    chk("fp_level", int'(fifo_level), 8);
    feed(50); feed(50); feed(50);
    out_ready = 1'b1;
    feed(50);
    out_ready = 1'b0;
    chk("fp_level_kept", int'(fifo_level), 8);
    chk("fp_ovf_clear", int'(overflow), 0);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk("fp_drain_sig", int'(out_sig), (r < 7) ? 11 + r : 50);
      tick();
    end
    chk("fp_level_end", int'(fifo_level), 0);

    // Asynchronous reset mid-block with results queued.
    out_ready = 1'b0;
    feed4(7); feed4(8); feed4(9);
    chk("ar_level", int'(fifo_level), 3);
    feed(100); feed(100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_level0", int'(fifo_level), 0);
    chk("ar_sig", int'(out_sig), 0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    feed(4); feed(8);
    chk("ar_no_partial", int'(out_valid), 0);
    feed(12); feed(16);
    chk("ar_valid_after", int'(out_valid), 1);
    chk("ar_sig_after", int'(out_sig), 10);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
